logic_gate_pipe: RTL and testbench

//  Parametrised, pipelined successor to the 2-input AND primitive. Combines NUM_IN

---
 rtl/logic_gate_pipe.sv | 111 +++++++++++
 tb/tb_logic_gate_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: reduces NUM_IN operands with a runtime-selected bitwise op
// (AND/OR/XOR/NAND/NOR/XNOR/NOT/PASS). The result passes through a 2-stage
// valid/ready pipeline. Stage 1 captures the operands and the op. Stage 2
// computes the result and registers it.
// Optional feature: define LOGIC_GATE_PIPE_CNT_EN to build a wrapping counter of
// completed output transfers on xfer_cnt. Without it, xfer_cnt is tied to 0.
module logic_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_op,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_any,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        xfer_cnt
);

  logic                    s1_valid;
  logic [NUM_IN*WIDTH-1:0] s1_data;
  logic [2:0]              s1_op;
  logic                    adv1;
  logic                    adv2;
  logic [WIDTH-1:0]        red_and;
  logic [WIDTH-1:0]        red_or;
  logic [WIDTH-1:0]        red_xor;
  logic [WIDTH-1:0]        op0;
  logic [WIDTH-1:0]        result;

  // An empty stage always advances. This lets bubbles collapse and lets stage 1 fill during a stall.
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // Stage 1: capture operands only for real transfers, so idle-cycle X never enters the pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_op    <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_op   <= in_op;
      end
    end
  end

  // Bitwise reductions across all operands, then op select on the stage-1 contents
  always_comb begin
    red_and = '1;
    red_or  = '0;
    red_xor = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      red_and = red_and & s1_data[k*WIDTH +: WIDTH];
      red_or  = red_or  | s1_data[k*WIDTH +: WIDTH];
      red_xor = red_xor ^ s1_data[k*WIDTH +: WIDTH];
    end
    op0 = s1_data[WIDTH-1:0];
    case (s1_op)
      3'd0:    result = red_and;
      3'd1:    result = red_or;
      3'd2:    result = red_xor;
      3'd3:    result = ~red_and;
      3'd4:    result = ~red_or;
      3'd5:    result = ~red_xor;
      3'd6:    result = ~op0;
      default: result = op0;
    endcase
  end

  // Stage 2: register the result. It holds while the downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_any   <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= result;
        out_any  <= |result;
      end
    end
  end

`ifdef LOGIC_GATE_PIPE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count completed output transfers. The counter wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
module tb_logic_gate_pipe;
  localparam int W   = 8;
  localparam int N   = 3;
  localparam int CW  = 4;
`ifdef LOGIC_GATE_PIPE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk = 0;
  logic          rst = 1;
  logic [N*W-1:0] in_data = '0;
  logic [2:0]    in_op = '0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_any;
  logic          out_valid;
  logic          out_ready = 0;
  logic [CW-1:0] xfer_cnt;

  logic [W-1:0]  d1_data = '0;
  logic [2:0]    d1_op = '0;
  logic          d1_valid = 0;
  logic          d1_ready;
  logic [W-1:0]  d1_out;
  logic          d1_any;
  logic          d1_ovalid;
  logic          d1_oready = 1;
  logic [CW-1:0] d1_cnt;

  logic_gate_pipe #(.WIDTH(W), .NUM_IN(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_op(in_op), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_any(out_any), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt));

  logic_gate_pipe #(.WIDTH(W), .NUM_IN(1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst(rst), .in_data(d1_data), .in_op(d1_op), .in_valid(d1_valid),
    .in_ready(d1_ready), .out_data(d1_out), .out_any(d1_any), .out_valid(d1_ovalid),
    .out_ready(d1_oready), .xfer_cnt(d1_cnt));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: per bit, count the operands with a 1 there and apply the op's rule
  function automatic logic [W-1:0] model(input logic [N*W-1:0] d, input logic [2:0] op);
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) begin
      int ones = 0;
      logic v;
      for (int k = 0; k < N; k++) ones += int'(d[k*W + b]);
      case (op)
        3'd0, 3'd3: v = (ones == N);
        3'd1, 3'd4: v = (ones > 0);
        3'd2, 3'd5: v = (ones % 2 == 1);
        3'd6:       v = ~d[b];
        default:    v = d[b];
      endcase
      r[b] = (op >= 3 && op <= 5) ? ~v : v;
    end
    return r;
  endfunction

  // Scoreboard
  logic [W-1:0] sb_data[$];
  int           out_cyc[$];
  int           cyc = 0;
  int           cnt_exp = 0;
  logic         prev_stall = 0;
  logic [W-1:0] prev_data;
  logic         prev_any;

  always @(posedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, (sb_data.size() < 2) || out_ready);
      chk("xfer_cnt", xfer_cnt, CNT_ON ? cnt_exp : 0);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_any", out_any, prev_any);
      end
      if (out_valid && out_ready) begin
        if (sb_data.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          logic [W-1:0] e;
          e = sb_data.pop_front();
          chk("sb_data", out_data, e);
          chk("sb_any", out_any, |e);
        end
        out_cyc.push_back(cyc);
        cnt_exp = (cnt_exp + 1) % (1 << CW);
      end
      if (in_valid && in_ready) sb_data.push_back(model(in_data, in_op));
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_any   = out_any;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N*W-1:0] d, input logic [2:0] op);
    bit done = 0;
    in_data  = d;
    in_op    = op;
    in_valid = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 0, 1);
    in_valid = 0;
    in_data  = 'x;
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a0, a1, a2;
    logic [W-1:0] exp_data;
    logic         exp_any;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{3'd0, 8'hF0, 8'hCC, 8'hAA, 8'h80, 1'b1};
    vecs[1]  = '{3'd1, 8'hF0, 8'hCC, 8'hAA, 8'hFE, 1'b1};
    vecs[2]  = '{3'd2, 8'hF0, 8'hCC, 8'hAA, 8'h96, 1'b1};
    vecs[3]  = '{3'd3, 8'hF0, 8'hCC, 8'hAA, 8'h7F, 1'b1};
    vecs[4]  = '{3'd4, 8'hF0, 8'hCC, 8'hAA, 8'h01, 1'b1};
    vecs[5]  = '{3'd5, 8'hF0, 8'hCC, 8'hAA, 8'h69, 1'b1};
    vecs[6]  = '{3'd6, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 1'b1};
    vecs[7]  = '{3'd7, 8'hF0, 8'hCC, 8'hAA, 8'hF0, 1'b1};
    vecs[8]  = '{3'd0, 8'h0F, 8'hF0, 8'h00, 8'h00, 1'b0};
    vecs[9]  = '{3'd5, 8'h0F, 8'hF0, 8'h00, 8'h00, 1'b0};
    vecs[10] = '{3'd1, 8'h0F, 8'hF0, 8'h00, 8'hFF, 1'b1};

    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_any", out_any, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    #20;
    rst = 0;
    tick();

    // Table vectors: latency 2 with out_ready high
    out_ready = 1;
    foreach (vecs[i]) begin
      in_data  = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
      in_op    = vecs[i].op;
      in_valid = 1;
      #1;
      chk("vec_in_ready", in_ready, 1);
      tick();
      in_valid = 0;
      chk("vec_lat1_valid", out_valid, 0);
      tick();
      chk("vec_lat2_valid", out_valid, 1);
      chk("vec_data", out_data, vecs[i].exp_data);
      chk("vec_any", out_any, vecs[i].exp_any);
    end
    tick();

    // Back-to-back: 4 results on consecutive cycles
    begin
      int base;
      base = out_cyc.size();
      for (int i = 0; i < 4; i++) send({8'hAA, 8'hCC, 8'(8'h10 + i)}, 3'(i));
      repeat (4) tick();
      chk("b2b_count", out_cyc.size() - base, 4);
      if (out_cyc.size() >= base + 4) chk("b2b_span", out_cyc[base+3] - out_cyc[base], 3);
    end

    // Stall: 2 accepted, 3rd refused, output frozen, then all drain in order
    out_ready = 0;
    send({8'hAA, 8'hCC, 8'hF0}, 3'd0);
    send({8'hAA, 8'hCC, 8'hF0}, 3'd2);
    chk("stall_valid_full", out_valid, 1);
    chk("stall_first", out_data, 8'h80);
    in_data  = {8'hAA, 8'hCC, 8'hF0};
    in_op    = 3'd7;
    in_valid = 1;
    #1;
    chk("stall_ready0", in_ready, 0);
    tick();
    tick();
    chk("stall_ready0_b", in_ready, 0);
    chk("stall_frozen", out_data, 8'h80);
    out_ready = 1;
    send({8'hAA, 8'hCC, 8'hF0}, 3'd7);
    repeat (4) tick();
    chk("stall_drained", sb_data.size(), 0);

    // Random traffic with random back-pressure; X data on idle cycles
    for (int i = 0; i < 400; i++) begin
      out_ready = 1'($urandom_range(0, 3) != 0);
      in_valid  = 1'($urandom);
      in_op     = 3'($urandom);
      in_data   = in_valid ? (N*W)'($urandom) : 'x;
      tick();
    end
    in_valid  = 0;
    out_ready = 1;
    repeat (4) tick();
    chk("rand_drained", sb_data.size(), 0);

    // Reset with 2 in flight
    out_ready = 0;
    send({8'h01, 8'h02, 8'h03}, 3'd1);
    send({8'h04, 8'h05, 8'h06}, 3'd1);
    #2;
    rst = 1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_any", out_any, 0);
    sb_data.delete();
    cnt_exp    = 0;
    prev_stall = 0;
    tick();
    rst = 0;
    out_ready = 1;
    tick();
    chk("postrst_valid", out_valid, 0);
    // 17 transfers after reset: counter wraps to 1 when enabled
    for (int i = 0; i < 17; i++) send({8'h00, 8'hFF, 8'(i)}, 3'd2);
    repeat (3) tick();
    chk("cnt_wrap17", xfer_cnt, CNT_ON ? 1 : 0);

    // NUM_IN=1 instance: all ops
    for (int v = 0; v < 2; v++) begin
      logic [W-1:0] a;
      a = (v == 0) ? 8'h3C : 8'h5A;
      for (int op = 0; op < 8; op++) begin
        logic [W-1:0] e;
        e = (op == 0 || op == 1 || op == 2 || op == 7) ? a : ~a;
        d1_data  = a;
        d1_op    = 3'(op);
        d1_valid = 1;
        tick();
        d1_valid = 0;
        tick();
        chk("n1_valid", d1_ovalid, 1);
        chk("n1_data", d1_out, e);
        chk("n1_any", d1_any, |e);
      end
    end
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
